// File: rtl/mem_arb_pkg.sv
// Shared types for the image-memory arbiter: bus word types, FSM state,
// and the burst counter width.
package mem_arb_pkg;
  typedef logic [15:0] halfword_t;
  typedef logic [31:0] word_t;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int BCNT_W = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side bus of the arbiter. The arbiter takes the
// slave modport; the requesters plus the memory sit on the master side.
interface mem_arbiter_if #(parameter int N_REQ = 2);
  import mem_arb_pkg::*;

  logic      [N_REQ-1:0] req;
  logic      [N_REQ-1:0] lock;
  halfword_t [N_REQ-1:0] r_addr;
  logic      [N_REQ-1:0] r_we;
  word_t     [N_REQ-1:0] r_dataW;
  logic      [N_REQ-1:0] gnt;
  logic      [N_REQ-1:0] rvalid;
  word_t                 dataR;

  logic                  mem_en;
  logic                  mem_we;
  halfword_t             mem_addr;
  word_t                 mem_dataW;
  word_t                 mem_dataR;

  modport slave (
    input  req, lock, r_addr, r_we, r_dataW, mem_dataR,
    output gnt, rvalid, dataR, mem_en, mem_we, mem_addr, mem_dataW
  );

  modport master (
    output req, lock, r_addr, r_we, r_dataW, mem_dataR,
    input  gnt, rvalid, dataR, mem_en, mem_we, mem_addr, mem_dataW
  );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester scanning from
// last+1 with wrap; one requester can optionally be excluded.
module rr_pick #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] idx
);
  logic [N_REQ-1:0] elig;
  logic [IDX_W-1:0] cand;

  for (genvar i = 0; i < N_REQ; i++) begin : g_elig
    assign elig[i] = req[i] & ~(excl_en && (excl_idx == IDX_W'(i)));
  end

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(last) + k) % N_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between N_REQ
// requesters, with per-ownership burst limit and lock override.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  localparam int               IDX_W      = $clog2(N_REQ);
  localparam logic [BCNT_W-1:0] BURST_LAST = BCNT_W'(MAX_BURST - 1);

  arb_state_t        state, state_nxt;
  logic [IDX_W-1:0]  owner, owner_nxt;
  logic [IDX_W-1:0]  last, last_nxt;
  logic [BCNT_W-1:0] burst_cnt, burst_nxt;
  logic              rd_pend;
  logic [IDX_W-1:0]  rd_id;

  logic              busy, owner_req, issue, rel;
  logic [IDX_W-1:0]  pick_last, pick_idx;
  logic              pick_found;

  assign busy      = (state == BUSY);
  assign owner_req = bus.req[owner];
  assign issue     = busy && owner_req;
  // In BUSY the picker scans from owner+1 and skips the owner, so its result
  // is both "someone else waits" and the handover winner with last = owner.
  assign pick_last = busy ? owner : last;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (bus.req),
    .last     (pick_last),
    .excl_en  (busy),
    .excl_idx (owner),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  assign rel = busy && (!owner_req ||
               (issue && (burst_cnt == BURST_LAST) && !bus.lock[owner] && pick_found));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IDX_W'(N_REQ - 1);
      burst_cnt <= '0;
      rd_pend   <= 1'b0;
      rd_id     <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
      rd_pend   <= issue && !bus.r_we[owner];
      rd_id     <= owner;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    burst_nxt = burst_cnt;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = BUSY;
          owner_nxt = pick_idx;
          burst_nxt = '0;
        end
      end
      BUSY: begin
        // Saturate one short of the limit so a later lock drop still hands over.
        if (issue && (burst_cnt != BURST_LAST))
          burst_nxt = burst_cnt + 1'b1;
        if (rel) begin
          last_nxt = owner;
          if (pick_found) begin
            owner_nxt = pick_idx;
            burst_nxt = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt       = '0;
    bus.rvalid    = '0;
    bus.mem_en    = issue;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_dataW = '0;
    bus.dataR     = bus.mem_dataR;
    if (busy)
      bus.gnt[owner] = owner_req;
    if (issue) begin
      bus.mem_we    = bus.r_we[owner];
      bus.mem_addr  = bus.r_addr[owner];
      bus.mem_dataW = bus.r_dataW[owner];
    end
    if (rd_pend)
      bus.rvalid[rd_id] = 1'b1;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses per requester, expected
// grants and read returns queued up front, negedge monitor compares.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = 2;
  localparam int MB = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mem_arbiter_if #(.N_REQ(N)) bus ();
  mem_arbiter #(.N_REQ(N), .MAX_BURST(MB)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int        id;
    logic      we;
    halfword_t addr;
    word_t     data;
    int        gap;
    logic      lock;
  } acc_t;

  typedef struct {
    int    id;
    word_t data;
  } rd_t;

  acc_t  gq[$];
  rd_t   rq[$];
  acc_t  dq[N][$];
  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    last_gnt = 0;
  word_t mem [0:65535];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model: unwritten words read back as A500_<addr>.
  initial for (int i = 0; i < 65536; i++) mem[i] = {16'hA500, 16'(i)};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_dataW;
      else            bus.mem_dataR     <= mem[bus.mem_addr];
    end
  end

  always @(negedge clk) begin : mon
    acc_t e;
    rd_t  d;
    if (bus.gnt != '0) begin
      check("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
      if (gq.size() == 0) begin
        check("gnt_unexpected", 64'(bus.gnt), 64'd0);
      end else begin
        e = gq.pop_front();
        check("gnt_id",   64'(bus.gnt),      64'(N'(1) << e.id));
        check("mem_en",   64'(bus.mem_en),   64'd1);
        check("mem_we",   64'(bus.mem_we),   64'(e.we));
        check("mem_addr", 64'(bus.mem_addr), 64'(e.addr));
        if (e.we) check("mem_dataW", 64'(bus.mem_dataW), 64'(e.data));
        if (e.gap != 0) check("gnt_gap", 64'(cyc - last_gnt), 64'(e.gap));
      end
      last_gnt = cyc;
    end
    if (bus.rvalid != '0) begin
      if (rq.size() == 0) begin
        check("rvalid_unexpected", 64'(bus.rvalid), 64'd0);
      end else begin
        d = rq.pop_front();
        check("rvalid_id", 64'(bus.rvalid), 64'(N'(1) << d.id));
        check("dataR",     64'(bus.dataR),  64'(d.data));
      end
    end
  end

  task automatic add(input int r, input logic we, input halfword_t a, input word_t dat,
                     input int gap, input logic lk);
    acc_t e;
    e.id = r; e.we = we; e.addr = a; e.data = dat; e.gap = gap; e.lock = lk;
    dq[r].push_back(e);
  endtask

  task automatic exp_g(input int r, input logic we, input halfword_t a, input word_t dat,
                       input int gap);
    acc_t e;
    e.id = r; e.we = we; e.addr = a; e.data = dat; e.gap = gap; e.lock = 1'b0;
    gq.push_back(e);
  endtask

  task automatic exp_r(input int r, input word_t dat);
    rd_t d;
    d.id = r; d.data = dat;
    rq.push_back(d);
  endtask

  function automatic int pending();
    int s = 0;
    for (int r = 0; r < N; r++) s += dq[r].size();
    return s;
  endfunction

  // Streams each requester's queue; gap = idle cycles before that access.
  task automatic run(input int budget);
    int n;
    int gapc [N];
    n = 0;
    for (int r = 0; r < N; r++) gapc[r] = (dq[r].size() != 0) ? dq[r][0].gap : 0;
    while (pending() != 0 && n < budget) begin
      for (int r = 0; r < N; r++) begin
        if (dq[r].size() != 0 && gapc[r] == 0) begin
          bus.req[r]     = 1'b1;
          bus.lock[r]    = dq[r][0].lock;
          bus.r_we[r]    = dq[r][0].we;
          bus.r_addr[r]  = dq[r][0].addr;
          bus.r_dataW[r] = dq[r][0].data;
        end else begin
          bus.req[r]  = 1'b0;
          bus.lock[r] = 1'b0;
          if (gapc[r] > 0) gapc[r]--;
        end
      end
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (bus.gnt[r] && dq[r].size() != 0) begin
          void'(dq[r].pop_front());
          if (dq[r].size() != 0) gapc[r] = dq[r][0].gap;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    bus.req  = '0;
    bus.lock = '0;
    check("run_drained", 64'(pending()), 64'd0);
    for (int r = 0; r < N; r++) dq[r].delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    bus.req     = '1;
    bus.lock    = '0;
    bus.r_we    = '1;
    bus.r_addr  = {N{16'h1234}};
    bus.r_dataW = {N{32'h5555_AAAA}};
    @(negedge clk);
    check("rst_gnt",       64'(bus.gnt),       64'd0);
    check("rst_rvalid",    64'(bus.rvalid),    64'd0);
    check("rst_mem_en",    64'(bus.mem_en),    64'd0);
    check("rst_mem_we",    64'(bus.mem_we),    64'd0);
    check("rst_mem_addr",  64'(bus.mem_addr),  64'd0);
    check("rst_mem_dataW", 64'(bus.mem_dataW), 64'd0);
    @(posedge clk); #1;
    bus.req  = '0;
    bus.r_we = '0;
    reset    = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    bus.req = '0; bus.lock = '0; bus.r_we = '0; bus.r_addr = '0; bus.r_dataW = '0;
    @(posedge clk); #1;

    // Single read from idle: gnt one cycle after req, rvalid one cycle later.
    do_reset();
    exp_g(0, 1'b0, 16'h0010, '0, 0);
    exp_r(0, 32'hA500_0010);
    bus.req[0] = 1'b1; bus.r_we[0] = 1'b0; bus.r_addr[0] = 16'h0010;
    @(negedge clk);
    check("t1_no_gnt_c1", 64'(bus.gnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_gnt_c2", 64'(bus.gnt), 64'd1);
    @(posedge clk); #1;
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("t1_rvalid_c3", 64'(bus.rvalid), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // Both request: 16 for r0, zero-gap handover to r1 for 16, back to r0.
    do_reset();
    for (int i = 0; i < 20; i++) add(0, 1'b1, 16'h0100 + 16'(i), 32'h1000_0000 + 32'(i), 0, 1'b0);
    for (int i = 0; i < 16; i++) add(1, 1'b0, 16'h0200 + 16'(i), '0, 0, 1'b0);
    for (int i = 0; i < 16; i++) exp_g(0, 1'b1, 16'h0100 + 16'(i), 32'h1000_0000 + 32'(i), (i == 0) ? 0 : 1);
    for (int i = 0; i < 16; i++) begin
      exp_g(1, 1'b0, 16'h0200 + 16'(i), '0, 1);
      exp_r(1, {16'hA500, 16'h0200 + 16'(i)});
    end
    for (int i = 16; i < 20; i++) exp_g(0, 1'b1, 16'h0100 + 16'(i), 32'h1000_0000 + 32'(i), 1);
    run(200);

    // Locked burst of 40 writes beyond MAX_BURST; r1 waits until r0 drops req.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      add(0, 1'b1, 16'h0300 + 16'(i), 32'h3000_0000 + 32'(i), 0, 1'b1);
      exp_g(0, 1'b1, 16'h0300 + 16'(i), 32'h3000_0000 + 32'(i), (i == 0) ? 0 : 1);
    end
    add(1, 1'b0, 16'h0400, '0, 0, 1'b0);
    exp_g(1, 1'b0, 16'h0400, '0, 2);
    exp_r(1, 32'hA500_0400);
    run(200);

    // Alternating single reads: grants 0,1,0,1, rvalid only to the issuer.
    do_reset();
    add(0, 1'b0, 16'h0500, '0, 0, 1'b0);
    add(0, 1'b0, 16'h0501, '0, 1, 1'b0);
    add(1, 1'b0, 16'h0600, '0, 0, 1'b0);
    add(1, 1'b0, 16'h0601, '0, 1, 1'b0);
    exp_g(0, 1'b0, 16'h0500, '0, 0); exp_r(0, 32'hA500_0500);
    exp_g(1, 1'b0, 16'h0600, '0, 2); exp_r(1, 32'hA500_0600);
    exp_g(0, 1'b0, 16'h0501, '0, 2); exp_r(0, 32'hA500_0501);
    exp_g(1, 1'b0, 16'h0601, '0, 2); exp_r(1, 32'hA500_0601);
    run(100);

    // Write through r1, read back through r0.
    do_reset();
    add(1, 1'b1, 16'h6300, 32'hDEAD_BEEF, 0, 1'b0);
    exp_g(1, 1'b1, 16'h6300, 32'hDEAD_BEEF, 0);
    run(50);
    add(0, 1'b0, 16'h6300, '0, 0, 1'b0);
    exp_g(0, 1'b0, 16'h6300, '0, 0);
    exp_r(0, 32'hDEAD_BEEF);
    run(50);

    // Reset right after a read grant drops the read; r0 then wins first.
    do_reset();
    exp_g(0, 1'b0, 16'h0020, '0, 0);
    bus.req[0] = 1'b1; bus.r_we[0] = 1'b0; bus.r_addr[0] = 16'h0020;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      seen = bus.gnt[0];
      if (!seen) begin @(posedge clk); #1; end
    end
    check("t6_gnt_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    reset   = 1'b0;
    bus.req = '0;
    @(negedge clk);
    check("t6_rvalid_in_reset", 64'(bus.rvalid), 64'd0);
    check("t6_mem_en_in_reset", 64'(bus.mem_en), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("t6_rvalid_later", 64'(bus.rvalid), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    add(0, 1'b0, 16'h0700, '0, 0, 1'b0);
    add(1, 1'b0, 16'h0701, '0, 0, 1'b0);
    exp_g(0, 1'b0, 16'h0700, '0, 0); exp_r(0, 32'hA500_0700);
    exp_g(1, 1'b0, 16'h0701, '0, 2); exp_r(1, 32'hA500_0701);
    run(50);

    repeat (3) @(posedge clk);
    #1;
    check("end_gnt_queue",  64'(gq.size()), 64'd0);
    check("end_read_queue", 64'(rq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter that shares the single-port image memory between `N_REQ` requesters, e.g. the edge-detection accelerator and a host loader or second accelerator instance. Each requester keeps the accelerator's memory bus style (`addr`, `dataW`, `we`) and adds a `req`/`gnt` handshake. The arbiter forwards exactly one access per cycle to the memory and returns read data one cycle later. It bounds each ownership to `MAX_BURST` accesses unless the owner asserts `lock`.

## Interface
- `N_REQ`, 2: number of requesters, 2..8.
- `MAX_BURST`, 16: accesses per ownership before forced handover, 1..256.
- `clk` in 1: the clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in N_REQ: access request per requester; held until serviced.
- `lock` in N_REQ: owner asks to suppress forced handover.
- `r_addr` in N_REQ×16: halfword_t word address per requester.
- `r_we` in N_REQ: 1 = write, 0 = read.
- `r_dataW` in N_REQ×32: write data (word_t).
- `gnt` out N_REQ: one-hot or zero; access of that requester is issued this cycle.
- `rvalid` out N_REQ: read data for that requester is valid on `dataR` this cycle.
- `dataR` out 32: broadcast copy of `mem_dataR`.
- `mem_en` out 1, `mem_we` out 1, `mem_addr` out 16, `mem_dataW` out 32: memory port.
- `mem_dataR` in 32: synchronous memory read data, valid the cycle after a read access.

## Operation
- Registered state (`arb_state_t`): IDLE, BUSY.
- Registered signals: `owner` (index), `last` (index of the previous owner), `burst_cnt` (8 b), `rd_pend` (1 b), `rd_id` (index).
- IDLE:
  - `gnt = 0`, `mem_en = 0`.
  - If any `req` is set, the round-robin winner is the first requester set in `req` scanning from `last+1` and wrapping modulo N_REQ.
  - Load `owner = winner` and `burst_cnt = 0`, then go to BUSY. No access is issued in this cycle.
- BUSY:
  - `gnt[owner] = req[owner]` combinationally.
  - If `req[owner] = 1`, the memory port is driven from the owner's inputs this cycle: `mem_en = 1`, `mem_we = r_we[owner]`, `mem_addr = r_addr[owner]`, `mem_dataW = r_dataW[owner]`. `burst_cnt` increments.
- Release, evaluated in BUSY. Either condition releases ownership:
  - (a) `req[owner] = 0`. No access is issued this cycle.
  - (b) An access is issued, `burst_cnt = MAX_BURST-1`, `lock[owner] = 0`, and another requester has `req` set.
- On release, set `last = owner`.
  - If another requester (excluding the old owner) is pending, hand over directly: `owner` takes the RR winner, `burst_cnt = 0`, and the state stays BUSY.
  - Otherwise go to IDLE.
- Burst limit:
  - If `burst_cnt` reaches MAX_BURST while no one else is requesting, or while `lock` is set, `burst_cnt` saturates and the owner keeps its grant.
  - Forced handover happens only after an access completes, so nothing is torn mid-access.
- Reads:
  - A read access sets `rd_pend = 1` and `rd_id = owner`.
  - Next cycle, `rvalid[rd_id] = rd_pend`. `dataR` always equals `mem_dataR`.
- Writes complete in the cycle `gnt` is high. A write produces no `rvalid`.
- Requester contract: `r_addr`, `r_we` and `r_dataW` are stable while `req` is high and `gnt` is low. A requester may change them the cycle after each `gnt` to stream consecutive accesses.

## Timing
- Reset values:
  - Outputs: `gnt = 0`, `rvalid = 0`, `mem_en = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_dataW = 0`.
  - Registers: state IDLE, `last = N_REQ-1` (requester 0 wins first), `burst_cnt = 0`, `rd_pend = 0`.
- Latency, request from idle:
  - The first `gnt` comes 1 cycle after `req` rises.
  - After that, one access per cycle while `req` stays high.
- Handover costs 0 dead cycles when another requester is pending.
- Read latency is 1 cycle from `gnt` to `rvalid`.
- Memory outputs are combinational from `owner` and the requester inputs. `gnt` is never high for two requesters at once.
- Simultaneous release and new request:
  - Requests present in the release cycle take part in that cycle's RR choice.
  - The old owner is lowest priority in that choice.
- Reset asserted mid-burst or mid-read: everything clears immediately and any in-flight read is dropped, so `rvalid` stays 0.

## Structure
- Package `mem_arb_pkg`:
  - `halfword_t` (16 b) and `word_t` (32 b).
  - `arb_state_t`.
  - Localparam for the width of `burst_cnt`.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector, `last`, `excl_en`, `excl_idx`.
  - Outputs: `found`, `idx`.
  - Instantiated once and shared by the IDLE and handover paths.
- `mem_arbiter` holds the FSM, counters, read-return tracking and memory muxing.

## Test plan
- Reset, then `req = 01` with a read at 0x0010: `gnt[0]` is high in cycle 2, `mem_addr = 0x0010`, `rvalid[0]` in cycle 3 with `dataR = mem[0x10]`.
- Both requesting from IDLE: requester 0 granted first. After 16 accesses, handover to requester 1 with no idle cycle and `gnt` never overlapping.
- Requester 0 holds `lock` for 40 writes while requester 1 waits: all 40 are granted back-to-back, then requester 1 is granted the cycle after requester 0 drops `req`.
- Alternating single reads from both requesters (N_REQ = 2): grants alternate 0,1,0,1 and each `rvalid` goes only to the issuer.
- Write 0xDEADBEEF at 0x6300 via requester 1, then read it back via requester 0: `dataR = 0xDEADBEEF`.
- Assert `reset` low in the cycle right after a read grant: `rvalid` stays 0, `mem_en = 0`, and after release requester 0 is the first winner.
